// File: rtl/rtc_time_ascii_tx_pkg.sv
// Shared constants for the RTC-to-ASCII frame formatter: FSM encodings,
// ASCII codes and frame-length constants.
package rtc_fmt_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  typedef struct packed {
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
  } rtc_snapshot_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_P     = 8'h50;
  localparam logic [7:0] ASCII_M     = 8'h4D;

  // Byte count before the EOL: "HH:MM:SS" or "HH:MM:SS AM"
  localparam logic [3:0] BODY_LEN_24H = 4'd8;
  localparam logic [3:0] BODY_LEN_12H = 4'd11;

endpackage

// File: rtl/rtc_time_ascii_tx_if.sv
// Snapshot input and tx_module level handshake between the RTC read side,
// the formatter and the UART transmitter.
interface rtc_time_ascii_tx_if;

  logic       time_valid;
  logic [7:0] hour_bcd;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       tx_en_sig;
  logic [7:0] tx_data;
  logic       tx_done;

  modport master (
    output time_valid, hour_bcd, min_bcd, sec_bcd, tx_done,
    input  tx_en_sig, tx_data
  );

  modport slave (
    input  time_valid, hour_bcd, min_bcd, sec_bcd, tx_done,
    output tx_en_sig, tx_data
  );

endinterface

// File: rtl/rtc_time_ascii_tx_bcd_nibble_ascii.sv
// Converts one BCD nibble to its ASCII digit, or to BAD_CHAR when the
// nibble is not a decimal digit.
module bcd_nibble_ascii
  import rtc_fmt_pkg::*;
#(
  parameter logic [7:0] BAD_CHAR = 8'h3F
) (
  input  logic [3:0] i_nibble,
  output logic [7:0] o_ascii
);

  assign o_ascii = (i_nibble <= 4'd9) ? (ASCII_ZERO + {4'b0000, i_nibble}) : BAD_CHAR;

endmodule

// File: rtl/rtc_time_ascii_tx.sv
// Formats one DS1302 hour/min/sec snapshot as "HH:MM:SS[ AM|PM]<EOL>" and
// streams it byte by byte over the tx_module level handshake.
module rtc_time_ascii_tx
  import rtc_fmt_pkg::*;
#(
  parameter logic [7:0] SEP_CHAR = 8'h3A,
  parameter bit         EOL_CRLF = 1'b1,
  parameter logic [7:0] BAD_CHAR = 8'h3F
) (
  input  logic                clk,
  input  logic                rst,
  rtc_time_ascii_tx_if.slave  io_bus,
  output logic                o_busy,
  output logic                o_frame_done,
  output logic [7:0]          o_overrun_cnt
);

  logic [1:0]    r_state;
  logic [3:0]    r_idx;
  rtc_snapshot_t r_act;
  rtc_snapshot_t r_pend;
  logic          r_pendFull;
  logic          r_txEn;
  logic [7:0]    r_txData;
  logic          r_frameDone;
  logic [7:0]    r_overrunCnt;

  rtc_snapshot_t w_snap;
  logic          w_is12h;
  logic [3:0]    w_eolBase;
  logic [3:0]    w_lastIdx;
  logic [3:0]    w_selIdx;
  logic          w_atLast;
  logic          w_drain;
  logic          w_captureIdle;
  logic [3:0]    w_hourTensNib;
  logic [3:0]    w_minTensNib;
  logic [3:0]    w_secTensNib;
  logic [7:0]    w_hourTens;
  logic [7:0]    w_hourUnits;
  logic [7:0]    w_minTens;
  logic [7:0]    w_minUnits;
  logic [7:0]    w_secTens;
  logic [7:0]    w_secUnits;
  logic [7:0]    w_byte;
  logic          w_unusedBits;

  assign w_snap    = {io_bus.hour_bcd, io_bus.min_bcd, io_bus.sec_bcd};
  assign w_is12h   = r_act.hour[7];
  assign w_eolBase = w_is12h ? BODY_LEN_12H : BODY_LEN_24H;
  assign w_lastIdx = w_eolBase + (EOL_CRLF ? 4'd1 : 4'd0);
  assign w_atLast  = (r_idx == w_lastIdx);

  // In GAP the next byte is fetched so it lands together with tx_en_sig
  assign w_selIdx  = (r_state == ST_GAP) ? (r_idx + 4'd1) : r_idx;

  assign w_drain       = r_pendFull && ((r_state == ST_IDLE) || ((r_state == ST_GAP) && w_atLast));
  assign w_captureIdle = io_bus.time_valid && (r_state == ST_IDLE) && !r_pendFull;

  assign w_hourTensNib = w_is12h ? {3'b000, r_act.hour[4]} : {2'b00, r_act.hour[5:4]};
  assign w_minTensNib  = {1'b0, r_act.min[6:4]};
  assign w_secTensNib  = {1'b0, r_act.sec[6:4]};
  assign w_unusedBits  = ^{r_act.hour[6], r_act.min[7], r_act.sec[7]};

  bcd_nibble_ascii #(.BAD_CHAR(BAD_CHAR)) u_hourTens  (.i_nibble(w_hourTensNib),    .o_ascii(w_hourTens));
  bcd_nibble_ascii #(.BAD_CHAR(BAD_CHAR)) u_hourUnits (.i_nibble(r_act.hour[3:0]),  .o_ascii(w_hourUnits));
  bcd_nibble_ascii #(.BAD_CHAR(BAD_CHAR)) u_minTens   (.i_nibble(w_minTensNib),     .o_ascii(w_minTens));
  bcd_nibble_ascii #(.BAD_CHAR(BAD_CHAR)) u_minUnits  (.i_nibble(r_act.min[3:0]),   .o_ascii(w_minUnits));
  bcd_nibble_ascii #(.BAD_CHAR(BAD_CHAR)) u_secTens   (.i_nibble(w_secTensNib),     .o_ascii(w_secTens));
  bcd_nibble_ascii #(.BAD_CHAR(BAD_CHAR)) u_secUnits  (.i_nibble(r_act.sec[3:0]),   .o_ascii(w_secUnits));

  always_comb begin
    w_byte = ASCII_LF;
    case (w_selIdx)
      4'd0:    w_byte = w_hourTens;
      4'd1:    w_byte = w_hourUnits;
      4'd2:    w_byte = SEP_CHAR;
      4'd3:    w_byte = w_minTens;
      4'd4:    w_byte = w_minUnits;
      4'd5:    w_byte = SEP_CHAR;
      4'd6:    w_byte = w_secTens;
      4'd7:    w_byte = w_secUnits;
      default: begin
        if (w_is12h && (w_selIdx == 4'd8)) begin
          w_byte = ASCII_SPACE;
        end else if (w_is12h && (w_selIdx == 4'd9)) begin
          w_byte = r_act.hour[5] ? ASCII_P : ASCII_A;
        end else if (w_is12h && (w_selIdx == 4'd10)) begin
          w_byte = ASCII_M;
        end else if (EOL_CRLF && (w_selIdx == w_eolBase)) begin
          w_byte = ASCII_CR;
        end else begin
          w_byte = ASCII_LF;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= 4'd0;
      r_act       <= '0;
      r_txEn      <= 1'b0;
      r_txData    <= 8'h00;
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_drain) begin
            r_act   <= r_pend;
            r_idx   <= 4'd0;
            r_state <= ST_LOAD;
          end else if (io_bus.time_valid) begin
            r_act   <= w_snap;
            r_idx   <= 4'd0;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_txData <= w_byte;
          r_txEn   <= 1'b1;
          r_state  <= ST_SEND;
        end
        ST_SEND: begin
          if (io_bus.tx_done) begin
            r_txEn  <= 1'b0;
            r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (!w_atLast) begin
            r_idx    <= r_idx + 4'd1;
            r_txData <= w_byte;
            r_txEn   <= 1'b1;
            r_state  <= ST_SEND;
          end else begin
            r_frameDone <= 1'b1;
            if (r_pendFull) begin
              r_act   <= r_pend;
              r_idx   <= 4'd0;
              r_state <= ST_LOAD;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A snapshot arriving while the pending slot is being drained refills it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend       <= '0;
      r_pendFull   <= 1'b0;
      r_overrunCnt <= 8'h00;
    end else if (io_bus.time_valid && !w_captureIdle) begin
      if (!r_pendFull || w_drain) begin
        r_pend     <= w_snap;
        r_pendFull <= 1'b1;
      end else if (r_overrunCnt != 8'hFF) begin
        r_overrunCnt <= r_overrunCnt + 8'd1;
      end
    end else if (w_drain) begin
      r_pendFull <= 1'b0;
    end
  end

  assign io_bus.tx_en_sig = r_txEn;
  assign io_bus.tx_data   = r_txData;
  assign o_busy           = (r_state != ST_IDLE) || r_pendFull;
  assign o_frame_done     = r_frameDone;
  assign o_overrun_cnt    = r_overrunCnt;

endmodule

// File: tb/tb_rtc_time_ascii_tx.sv
// Directed bench for rtc_time_ascii_tx: a CRLF and an LF instance share one
// tx_module responder; expected bytes come from a queue filled at stimulus time.
module tb_rtc_time_ascii_tx;

  logic clk = 1'b0;
  logic rst;
  logic doneDrv;
  bit   selLf;

  always #5 clk = ~clk;

  rtc_time_ascii_tx_if ifCr();
  rtc_time_ascii_tx_if ifLf();

  logic       busyCr, frameDoneCr, busyLf, frameDoneLf;
  logic [7:0] overrunCr, overrunLf;

  assign ifCr.tx_done = doneDrv & ~selLf;
  assign ifLf.tx_done = doneDrv & selLf;

  rtc_time_ascii_tx #(.SEP_CHAR(8'h3A), .EOL_CRLF(1'b1), .BAD_CHAR(8'h3F)) dutCr (
    .clk(clk), .rst(rst), .io_bus(ifCr.slave),
    .o_busy(busyCr), .o_frame_done(frameDoneCr), .o_overrun_cnt(overrunCr)
  );

  rtc_time_ascii_tx #(.SEP_CHAR(8'h3A), .EOL_CRLF(1'b0), .BAD_CHAR(8'h3F)) dutLf (
    .clk(clk), .rst(rst), .io_bus(ifLf.slave),
    .o_busy(busyLf), .o_frame_done(frameDoneLf), .o_overrun_cnt(overrunLf)
  );

  logic       curEn, curBusy, curFrameDone;
  logic [7:0] curData, curOverrun;

  assign curEn        = selLf ? ifLf.tx_en_sig : ifCr.tx_en_sig;
  assign curData      = selLf ? ifLf.tx_data   : ifCr.tx_data;
  assign curBusy      = selLf ? busyLf         : busyCr;
  assign curFrameDone = selLf ? frameDoneLf    : frameDoneCr;
  assign curOverrun   = selLf ? overrunLf      : overrunCr;

  int         compared = 0;
  int         mismatched = 0;
  logic [7:0] expQ[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] digitAscii(input logic [3:0] d);
    return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
  endfunction

  // Reference formatter: pushes the expected frame and returns its length
  function automatic int pushFrame(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input bit crlf);
    logic [3:0] hTens;
    int n;
    hTens = h[7] ? {3'b000, h[4]} : {2'b00, h[5:4]};
    expQ.push_back(digitAscii(hTens));
    expQ.push_back(digitAscii(h[3:0]));
    expQ.push_back(8'h3A);
    expQ.push_back(digitAscii({1'b0, m[6:4]}));
    expQ.push_back(digitAscii(m[3:0]));
    expQ.push_back(8'h3A);
    expQ.push_back(digitAscii({1'b0, s[6:4]}));
    expQ.push_back(digitAscii(s[3:0]));
    n = 8;
    if (h[7]) begin
      expQ.push_back(8'h20);
      expQ.push_back(h[5] ? 8'h50 : 8'h41);
      expQ.push_back(8'h4D);
      n = 11;
    end
    if (crlf) begin
      expQ.push_back(8'h0D);
      n++;
    end
    expQ.push_back(8'h0A);
    n++;
    return n;
  endfunction

  task automatic driveSnapshot(input bit useLf, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    @(negedge clk);
    if (useLf) begin
      ifLf.time_valid = 1'b1; ifLf.hour_bcd = h; ifLf.min_bcd = m; ifLf.sec_bcd = s;
    end else begin
      ifCr.time_valid = 1'b1; ifCr.hour_bcd = h; ifCr.min_bcd = m; ifCr.sec_bcd = s;
    end
  endtask

  task automatic releaseValid();
    @(negedge clk);
    ifCr.time_valid = 1'b0;
    ifLf.time_valid = 1'b0;
  endtask

  task automatic applyStimulus(input bit useLf, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    selLf = useLf;
    driveSnapshot(useLf, h, m, s);
    releaseValid();
  endtask

  task automatic waitEn(input int bound, output int waited, output bit ok);
    waited = 0;
    while (!curEn && waited < bound) begin
      @(negedge clk);
      waited++;
    end
    ok = curEn;
    if (!ok) checkOutput("txEnTimeout", 32'(curEn), 32'd1);
  endtask

  // Acts as tx_module: holds each byte holdCycles, then pulses tx_done
  task automatic serviceFrame(input int nBytes, input int holdCycles, input int firstWait,
                              input bit fullFrame, input bit expBusy);
    int waited;
    bit ok;
    logic [7:0] held;
    logic [7:0] expByte;
    for (int i = 0; i < nBytes; i++) begin
      waitEn(20, waited, ok);
      if (!ok) return;
      checkOutput((i == 0) ? "firstLatency" : "gapCycles", 32'(waited), (i == 0) ? 32'(firstWait) : 32'd1);
      held = curData;
      repeat (holdCycles - 1) @(negedge clk);
      checkOutput("txEnHeld", 32'(curEn), 32'd1);
      checkOutput("txDataStable", 32'(curData), 32'(held));
      if (expQ.size() == 0) begin
        checkOutput("unexpectedByte", 32'(expQ.size()), 32'd1);
        return;
      end
      expByte = expQ.pop_front();
      checkOutput($sformatf("byte%0d", i), 32'(curData), 32'(expByte));
      doneDrv = 1'b1;
      @(negedge clk);
      doneDrv = 1'b0;
    end
    if (fullFrame) begin
      @(negedge clk);
      checkOutput("frameDone", 32'(curFrameDone), 32'd1);
      checkOutput("busyAfterFrame", 32'(curBusy), 32'(expBusy));
    end
  endtask

  initial begin
    int n;
    int waited;
    bit ok;
    rst = 1'b1;
    doneDrv = 1'b0;
    selLf = 1'b0;
    ifCr.time_valid = 1'b0; ifCr.hour_bcd = 8'h00; ifCr.min_bcd = 8'h00; ifCr.sec_bcd = 8'h00;
    ifLf.time_valid = 1'b0; ifLf.hour_bcd = 8'h00; ifLf.min_bcd = 8'h00; ifLf.sec_bcd = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("rstEnCr",      32'(ifCr.tx_en_sig), 32'd0);
    checkOutput("rstDataCr",    32'(ifCr.tx_data),   32'd0);
    checkOutput("rstBusyCr",    32'(busyCr),         32'd0);
    checkOutput("rstFrameCr",   32'(frameDoneCr),    32'd0);
    checkOutput("rstOverrunCr", 32'(overrunCr),      32'd0);
    checkOutput("rstEnLf",      32'(ifLf.tx_en_sig), 32'd0);
    checkOutput("rstBusyLf",    32'(busyLf),         32'd0);
    checkOutput("rstOverrunLf", 32'(overrunLf),      32'd0);
    rst = 1'b0;

    $display("[TB] 24h CRLF frame");
    applyStimulus(1'b0, 8'h13, 8'h45, 8'h07);
    n = pushFrame(8'h13, 8'h45, 8'h07, 1'b1);
    serviceFrame(n, 3, 1, 1'b1, 1'b0);

    $display("[TB] 12h PM LF frame");
    applyStimulus(1'b1, 8'hB1, 8'h05, 8'h80);
    n = pushFrame(8'hB1, 8'h05, 8'h80, 1'b0);
    serviceFrame(n, 2, 1, 1'b1, 1'b0);

    $display("[TB] 24h LF frame");
    applyStimulus(1'b1, 8'h23, 8'h59, 8'h59);
    n = pushFrame(8'h23, 8'h59, 8'h59, 1'b0);
    serviceFrame(n, 1, 1, 1'b1, 1'b0);

    $display("[TB] 12h AM CRLF frame");
    applyStimulus(1'b0, 8'h92, 8'h30, 8'h15);
    n = pushFrame(8'h92, 8'h30, 8'h15, 1'b1);
    serviceFrame(n, 2, 1, 1'b1, 1'b0);

    $display("[TB] bad BCD minute");
    applyStimulus(1'b0, 8'h09, 8'h6A, 8'h22);
    n = pushFrame(8'h09, 8'h6A, 8'h22, 1'b1);
    serviceFrame(n, 3, 1, 1'b1, 1'b0);

    $display("[TB] slow tx_module handshake");
    applyStimulus(1'b0, 8'h08, 8'h00, 8'h00);
    n = pushFrame(8'h08, 8'h00, 8'h00, 1'b1);
    serviceFrame(n, 5208, 1, 1'b1, 1'b0);

    $display("[TB] stray tx_done in IDLE");
    selLf = 1'b0;
    @(negedge clk);
    doneDrv = 1'b1;
    @(negedge clk);
    doneDrv = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("strayEn",    32'(curEn),        32'd0);
    checkOutput("strayBusy",  32'(curBusy),      32'd0);
    checkOutput("strayFrame", 32'(curFrameDone), 32'd0);

    $display("[TB] overrun with three back-to-back snapshots");
    selLf = 1'b0;
    driveSnapshot(1'b0, 8'h12, 8'h00, 8'h00);
    n = pushFrame(8'h12, 8'h00, 8'h00, 1'b1);
    driveSnapshot(1'b0, 8'h00, 8'h00, 8'h01);
    driveSnapshot(1'b0, 8'h17, 8'h17, 8'h17);
    releaseValid();
    checkOutput("overrunCnt",  32'(curOverrun), 32'd1);
    checkOutput("busyPending", 32'(curBusy),    32'd1);
    serviceFrame(n, 2, 0, 1'b1, 1'b1);
    n = pushFrame(8'h00, 8'h00, 8'h01, 1'b1);
    serviceFrame(n, 2, 1, 1'b1, 1'b0);
    checkOutput("overrunHeld", 32'(curOverrun), 32'd1);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b0, 8'h21, 8'h10, 8'h05);
    n = pushFrame(8'h21, 8'h10, 8'h05, 1'b1);
    serviceFrame(4, 2, 1, 1'b0, 1'b0);
    waitEn(20, waited, ok);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abortEn",      32'(curEn),        32'd0);
    checkOutput("abortBusy",    32'(curBusy),      32'd0);
    checkOutput("abortOverrun", 32'(curOverrun),   32'd0);
    checkOutput("abortFrame",   32'(curFrameDone), 32'd0);
    rst = 1'b0;
    expQ.delete();
    applyStimulus(1'b0, 8'h06, 8'h07, 8'h08);
    n = pushFrame(8'h06, 8'h07, 8'h08, 1'b1);
    serviceFrame(n, 2, 1, 1'b1, 1'b0);

    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
